// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues word requests to instruction memory
// over a req/ack handshake, buffers {pc, inst} pairs in a prefetch FIFO and
// hands them to decode with a valid/ready handshake. Redirects flush the FIFO
// and any in-flight response is dropped.
//
// state | meaning
// FETCH | normal fetching; acks push into the FIFO
// DROP  | a redirect left a request outstanding; its ack is discarded
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_next;
    logic [31:0]     r_addr;
    logic [31:0]     w_addr_next;
    logic            r_req;
    logic            w_req_next;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_next;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [31:0]     r_pc_mem   [DEPTH];
    logic [31:0]     r_inst_mem [DEPTH];
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_hold;
    logic [31:0]     w_redirect_pc;

    // An ack only means something while a request is actually outstanding.
    assign w_ack         = imem_ack & r_req;
    assign w_valid       = (r_count != '0);
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_hold        = r_req & ~w_ack;

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = w_valid;
    assign inst_out   = w_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
    assign inst_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;

    // Next-state, FIFO bookkeeping and request launch decisions.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_count_next    = r_count;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_req_next      = r_req;
        w_addr_next     = r_addr;

        if (redirect) begin
            // A request still waiting for its ack must be drained in DROP;
            // an ack arriving now is simply thrown away.
            w_fetch_pc_next = w_redirect_pc;
            w_count_next    = '0;
            w_state_next    = w_hold ? DROP : FETCH;
        end else begin
            w_pop = w_valid & inst_ready;
            case (r_state)
                FETCH: begin
                    w_push = w_ack;
                    if (w_push) begin
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                    end
                end
                DROP: begin
                    if (w_ack) begin
                        w_state_next = FETCH;
                    end
                end
                default: w_state_next = FETCH;
            endcase
            w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end

        // Address stays frozen until the outstanding request is acked; a
        // fresh request is only launched when the FIFO will have room.
        if (w_hold) begin
            w_req_next  = 1'b1;
            w_addr_next = r_addr;
        end else begin
            w_req_next  = (w_count_next < L_DEPTH);
            w_addr_next = w_fetch_pc_next;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_addr     <= w_addr_next;
            r_req      <= w_req_next;
            r_count    <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, slow memory with
// redirect/drop, redirect with ack, PC wrap, redirect on full FIFO and reset
// mid-stream.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        zw;
    logic        man_ack;
    int          checks;
    int          errors;

    localparam logic [31:0] XK = 32'hA5A5_0000;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    // Memory model: zero-wait (ack follows req) or hand-driven ack.
    assign imem_ack   = zw ? imem_req : man_ack;
    assign imem_rdata = imem_addr ^ XK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] e;
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        zw          = 1'b1;
        man_ack     = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        tick();
        tick();
        chk("rst_req",   {31'h0, imem_req},   32'h0);
        chk("rst_addr",  imem_addr,           32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst",  inst_out,            32'h0);
        chk("rst_pc",    inst_pc,             32'h0);

        // Zero-wait streaming, one word per cycle
        reset = 1'b1;
        tick();
        chk("a_req1",   {31'h0, imem_req},   32'h1);
        chk("a_addr1",  imem_addr,           32'h0);
        chk("a_valid1", {31'h0, inst_valid}, 32'h0);
        tick();
        chk("a_valid2", {31'h0, inst_valid}, 32'h1);
        chk("a_pc2",    inst_pc,             32'h0);
        chk("a_inst2",  inst_out,            32'hA5A5_0000);
        chk("a_addr2",  imem_addr,           32'h4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            e = 32'(4 * k);
            chk("a_pc_k",    inst_pc,             e);
            chk("a_inst_k",  inst_out,            e ^ XK);
            chk("a_valid_k", {31'h0, inst_valid}, 32'h1);
        end

        // Back-pressure: exactly DEPTH acks, then one pop refills one slot
        reset      = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk("b_async_req",   {31'h0, imem_req},   32'h0);
        chk("b_async_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("b_req1", {31'h0, imem_req}, 32'h1);
        tick();
        tick();
        tick();
        chk("b_addr4", imem_addr,         32'hC);
        chk("b_req4",  {31'h0, imem_req}, 32'h1);
        tick();
        chk("b_req_full",   {31'h0, imem_req}, 32'h0);
        chk("b_pc_full",    inst_pc,           32'h0);
        tick();
        tick();
        chk("b_req_idle", {31'h0, imem_req}, 32'h0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("b_req_refill",  {31'h0, imem_req}, 32'h1);
        chk("b_addr_refill", imem_addr,         32'h10);
        chk("b_pc_after",    inst_pc,           32'h4);
        tick();
        chk("b_req_full2",   {31'h0, imem_req},   32'h0);
        chk("b_valid_full2", {31'h0, inst_valid}, 32'h1);

        // Redirect on a full FIFO with an ack strobe and a pop
        zw          = 1'b0;
        man_ack     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        inst_ready  = 1'b1;
        tick();
        redirect = 1'b0;
        man_ack  = 1'b0;
        zw       = 1'b1;
        chk("d_valid", {31'h0, inst_valid}, 32'h0);
        chk("d_inst",  inst_out,            32'h0);
        chk("d_pc",    inst_pc,             32'h0);
        chk("d_req",   {31'h0, imem_req},   32'h1);
        chk("d_addr",  imem_addr,           32'h200);
        tick();
        chk("d_pc_new",   inst_pc,  32'h200);
        chk("d_inst_new", inst_out, 32'hA5A5_0200);

        // Reset mid-stream with three entries held
        inst_ready = 1'b0;
        tick();
        tick();
        chk("r_pc_head", inst_pc,           32'h200);
        chk("r_addr",    imem_addr,         32'h20C);
        chk("r_req",     {31'h0, imem_req}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_valid0", {31'h0, inst_valid}, 32'h0);
        chk("r_inst0",  inst_out,            32'h0);
        chk("r_pc0",    inst_pc,             32'h0);
        chk("r_req0",   {31'h0, imem_req},   32'h0);
        chk("r_addr0",  imem_addr,           32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("r_restart_req",  {31'h0, imem_req}, 32'h1);
        chk("r_restart_addr", imem_addr,         32'h0);
        tick();
        chk("r_restart_pc",   inst_pc,  32'h0);
        chk("r_restart_inst", inst_out, 32'hA5A5_0000);

        // Slow memory, redirect while request to 8 outstanding
        reset      = 1'b0;
        zw         = 1'b0;
        man_ack    = 1'b0;
        inst_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("c_req1", {31'h0, imem_req}, 32'h1);
        tick();
        tick();
        chk("c_addr_wait",  imem_addr,           32'h0);
        chk("c_valid_wait", {31'h0, inst_valid}, 32'h0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("c_pc0",   inst_pc,   32'h0);
        chk("c_addr4", imem_addr, 32'h4);
        tick();
        chk("c_valid_popped", {31'h0, inst_valid}, 32'h0);
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("c_pc4",   inst_pc,   32'h4);
        chk("c_addr8", imem_addr, 32'h8);
        tick();
        chk("c_addr8b", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        chk("c_drop_valid", {31'h0, inst_valid}, 32'h0);
        chk("c_drop_req",   {31'h0, imem_req},   32'h1);
        chk("c_drop_addr",  imem_addr,           32'h8);
        tick();
        chk("c_drop_addr2", imem_addr, 32'h8);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("c_discard_valid", {31'h0, inst_valid}, 32'h0);
        chk("c_new_req",       {31'h0, imem_req},   32'h1);
        chk("c_new_addr",      imem_addr,           32'h400);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("c_new_pc",   inst_pc,   32'h400);
        chk("c_new_inst", inst_out,  32'hA5A5_0400);
        chk("c_addr404",  imem_addr, 32'h404);

        // Redirect coinciding with ack, then PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        man_ack     = 1'b1;
        tick();
        redirect = 1'b0;
        man_ack  = 1'b0;
        chk("w_valid0", {31'h0, inst_valid}, 32'h0);
        chk("w_req",    {31'h0, imem_req},   32'h1);
        chk("w_addr",   imem_addr,           32'hFFFF_FFFC);
        zw = 1'b1;
        tick();
        chk("w_pc_top",   inst_pc,   32'hFFFF_FFFC);
        chk("w_inst_top", inst_out,  32'h5A5A_FFFC);
        chk("w_addr_wrap", imem_addr, 32'h0);
        tick();
        chk("w_pc_wrap",   inst_pc,   32'h0);
        chk("w_inst_wrap", inst_out,  32'hA5A5_0000);
        chk("w_addr_next", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
